// File: rtl/sync_fifo_ring.sv
// Ring-buffer synchronous FIFO with registered read data, occupancy flags and sticky error flags.
// Define SYNC_FIFO_MARKER_FILTER_EN to drop MARKER words on write and pulse start_o instead.
module sync_fifo_ring #(
  parameter int RAM_WIDTH    = 32,
  parameter int ADDR_LINES   = 12,
  parameter int AFULL_LEVEL  = (1 << ADDR_LINES) - 4,
  parameter int AEMPTY_LEVEL = 4,
  parameter logic [RAM_WIDTH-1:0] MARKER = 32'h7F90_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [RAM_WIDTH-1:0] data_i,
  output logic [RAM_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [ADDR_LINES:0]  count_o,
  output logic                 start_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int DEPTH = 1 << ADDR_LINES;
  localparam int CW    = ADDR_LINES + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [ADDR_LINES-1:0] PTR_ONE = ADDR_LINES'(1);

  logic [RAM_WIDTH-1:0]  mem_q [DEPTH];

  logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [RAM_WIDTH-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic filt;
  logic full, empty;
  logic wr_acc, rd_acc;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

`ifdef SYNC_FIFO_MARKER_FILTER_EN
  logic start_q;

  assign filt = wr_en && (data_i == MARKER);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) start_q <= 1'b0;
    else       start_q <= !clr_i && filt;
  end

  assign start_o = start_q;
`else
  assign filt    = 1'b0;
  assign start_o = 1'b0;
`endif

  // Flags come from pre-edge occupancy: no write-through or read-through bypass.
  assign wr_acc = !clr_i && wr_en && !full && !filt;
  assign rd_acc = !clr_i && rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        data_d   = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
      end
      if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
      if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
      if (wr_en && full && !filt) ovf_d = 1'b1;
      if (rd_en && empty)         unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is left uninitialised; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o         = data_q;
  assign valid_o        = valid_q;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
